// File: rtl/catraca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : catraca_pkg
// Description : Shared types and constants for the multi-card turnstile.
//               - state_t      : turnstile FSM states
//               - SEG_0..SEG_9 : 7-segment digit patterns (gfedcba, active-high)
//               - SEG_BLANK    : all segments off
// Revision    : 1.0 - initial release
// ============================================================================
package catraca_pkg;

    typedef enum logic [1:0] {
        LOCKED     = 2'd0,
        OPEN       = 2'd1,
        WAIT_CLEAR = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage : catraca_pkg
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : Decimal digit to 7-segment pattern (gfedcba, active-high).
//               Values 10..15 are shown blank.
// Ports       : value_i [3:0] - digit to display
//               seg_o   [6:0] - segment pattern
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder (
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);
    import catraca_pkg::*;

    always_comb begin
        seg_o = SEG_BLANK;
        case (value_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/catraca_multi.sv
`default_nettype none
// ============================================================================
// Module      : catraca_multi
// Description : Bus turnstile controller for NCARDS prepaid cards. Each card
//               holds a saturating credit balance. A tap either recharges the
//               card (recharge != 0) or pays FARE and opens the gate for
//               OPEN_CYCLES clocks. Exactly one transaction happens per tap;
//               the reader must go empty before the next one.
// Ports       : clk_2      - system clock (rising edge)
//               reset_n    - asynchronous active-low reset
//               card_sel   - one-hot card presence
//               recharge   - credits to add on this tap, 0 = pay-and-pass
//               gate_open  - turnstile released
//               denied     - one-cycle pulse on insufficient balance
//               err_multi  - more than one card on the reader
//               balance    - balance of the single presented card, else 0
//               seg        - 7-segment view of balance, blank if no single card
//               pass_count - passages since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module catraca_multi #(
    parameter int NCARDS      = 2,
    parameter int CRED_BITS   = 4,
    parameter int MAX_CREDIT  = 5,
    parameter int FARE        = 1,
    parameter int RCH_BITS    = 2,
    parameter int OPEN_CYCLES = 2,
    parameter int CNT_BITS    = 8
) (
    input  logic                 clk_2,
    input  logic                 reset_n,
    input  logic [NCARDS-1:0]    card_sel,
    input  logic [RCH_BITS-1:0]  recharge,
    output logic                 gate_open,
    output logic                 denied,
    output logic                 err_multi,
    output logic [CRED_BITS-1:0] balance,
    output logic [6:0]           seg,
    output logic [CNT_BITS-1:0]  pass_count
);
    import catraca_pkg::*;

    localparam int IDX_W = (NCARDS > 1) ? $clog2(NCARDS) : 1;
    localparam int TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    // One extra bit so the recharge sum cannot wrap before saturation.
    localparam int SUM_W = CRED_BITS + 1;

    localparam logic [CRED_BITS-1:0] FARE_C   = CRED_BITS'(FARE);
    localparam logic [CRED_BITS-1:0] MAX_C    = CRED_BITS'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]     MAX_S    = SUM_W'(MAX_CREDIT);
    localparam logic [TMR_W-1:0]     TMR_LOAD = TMR_W'(OPEN_CYCLES - 1);

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  denied_q, denied_d;
    logic [CNT_BITS-1:0]   pass_q, pass_d;
    logic [CRED_BITS-1:0]  bal_q [NCARDS];
    logic [CRED_BITS-1:0]  bal_d [NCARDS];

    logic                  seen;
    logic                  multi;
    logic                  single;
    logic [IDX_W-1:0]      idx;
    logic [SUM_W-1:0]      sum;
    logic [6:0]            seg_dec;

    // ------------------------------------------------------------------
    // Card presence decode: 'multi' is set when a second bit is found.
    // ------------------------------------------------------------------
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        idx   = '0;
        for (int i = 0; i < NCARDS; i++) begin
            if (card_sel[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                idx  = IDX_W'(i);
            end
        end
    end

    assign single = seen & ~multi;

    // ------------------------------------------------------------------
    // FSM next-state, balance and counter update
    // ------------------------------------------------------------------
    assign sum = {1'b0, bal_q[idx]} + SUM_W'(recharge);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        denied_d = 1'b0;
        pass_d   = pass_q;
        bal_d    = bal_q;
        case (state_q)
            LOCKED: begin
                if (single) begin
                    if (recharge != '0) begin
                        bal_d[idx] = (sum > MAX_S) ? MAX_C : sum[CRED_BITS-1:0];
                        state_d    = WAIT_CLEAR;
                    end else if (bal_q[idx] >= FARE_C) begin
                        bal_d[idx] = bal_q[idx] - FARE_C;
                        pass_d     = pass_q + CNT_BITS'(1);
                        timer_d    = TMR_LOAD;
                        state_d    = OPEN;
                    end else begin
                        denied_d   = 1'b1;
                        state_d    = WAIT_CLEAR;
                    end
                end
            end
            OPEN: begin
                // Timer loaded with OPEN_CYCLES-1 so the gate stays high
                // for exactly OPEN_CYCLES clocks including the exit cycle.
                if (timer_q == '0) begin
                    state_d = WAIT_CLEAR;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            WAIT_CLEAR: begin
                if (card_sel == '0) begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOCKED;
            timer_q  <= '0;
            denied_q <= 1'b0;
            pass_q   <= '0;
            for (int i = 0; i < NCARDS; i++) begin
                bal_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            denied_q <= denied_d;
            pass_q   <= pass_d;
            bal_q    <= bal_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. gate_open is decoded from the state register so that an
    // asynchronous reset closes the gate immediately.
    // ------------------------------------------------------------------
    assign gate_open  = (state_q == OPEN);
    assign denied     = denied_q;
    assign err_multi  = multi;
    assign pass_count = pass_q;
    assign balance    = single ? bal_q[idx] : '0;

    seg7_decoder u_seg7 (
        .value_i (4'(balance)),
        .seg_o   (seg_dec)
    );

    assign seg = single ? seg_dec : SEG_BLANK;

endmodule : catraca_multi
`default_nettype wire

// File: tb/tb_catraca_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_catraca_multi
// Description : Self-checking bench for catraca_multi. A vector table covers
//               the main tap sequences on the default configuration; short
//               hand-written sequences cover card holding, asynchronous reset
//               during OPEN, and pass counter wrap on a second instance
//               (NCARDS=4, FARE=2, CNT_BITS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_catraca_multi;

    localparam logic [6:0] B  = 7'b0000000;
    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;

    logic       clk;
    logic       rst_n;

    logic [1:0] sel;
    logic [1:0] rch;
    logic       gate, den, err;
    logic [3:0] bal;
    logic [6:0] sg;
    logic [7:0] pc;

    logic [3:0] sel2;
    logic [1:0] rch2;
    logic       gate2, den2, err2;
    logic [3:0] bal2;
    logic [6:0] sg2;
    logic [1:0] pc2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] rch;
        logic       gate;
        logic       den;
        logic       err;
        logic [3:0] bal;
        logic [6:0] seg;
        logic [7:0] pc;
    } vec_t;

    vec_t vq[$];

    catraca_multi dut (
        .clk_2      (clk),
        .reset_n    (rst_n),
        .card_sel   (sel),
        .recharge   (rch),
        .gate_open  (gate),
        .denied     (den),
        .err_multi  (err),
        .balance    (bal),
        .seg        (sg),
        .pass_count (pc)
    );

    catraca_multi #(
        .NCARDS   (4),
        .FARE     (2),
        .CNT_BITS (2)
    ) dut2 (
        .clk_2      (clk),
        .reset_n    (rst_n),
        .card_sel   (sel2),
        .recharge   (rch2),
        .gate_open  (gate2),
        .denied     (den2),
        .err_multi  (err2),
        .balance    (bal2),
        .seg        (sg2),
        .pass_count (pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: active edge, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t v(input logic [1:0] s, input logic [1:0] r,
                               input logic g, input logic d, input logic e,
                               input logic [3:0] b, input logic [6:0] sgv,
                               input logic [7:0] p);
        vec_t x;
        x.sel = s; x.rch = r; x.gate = g; x.den = d; x.err = e;
        x.bal = b; x.seg = sgv; x.pc = p;
        return x;
    endfunction

    initial begin
        int gcnt;
        int mb;

        rst_n = 1'b0;
        sel   = 2'b00;
        rch   = 2'd0;
        sel2  = 4'b0000;
        rch2  = 2'd0;

        // Each row: drive inputs, one clock, then expect these outputs.
        //            sel    rch  gate den err bal seg pc
        vq.push_back(v(2'b01, 2'd0, 0, 1, 0, 0, S0, 0)); // empty card: denied
        vq.push_back(v(2'b01, 2'd0, 0, 0, 0, 0, S0, 0)); // pulse is 1 cycle
        vq.push_back(v(2'b00, 2'd0, 0, 0, 0, 0, B,  0));
        vq.push_back(v(2'b01, 2'd3, 0, 0, 0, 3, S3, 0)); // recharge +3
        vq.push_back(v(2'b01, 2'd3, 0, 0, 0, 3, S3, 0)); // held: once only
        vq.push_back(v(2'b01, 2'd3, 0, 0, 0, 3, S3, 0));
        vq.push_back(v(2'b01, 2'd3, 0, 0, 0, 3, S3, 0));
        vq.push_back(v(2'b01, 2'd3, 0, 0, 0, 3, S3, 0));
        vq.push_back(v(2'b00, 2'd0, 0, 0, 0, 0, B,  0));
        vq.push_back(v(2'b01, 2'd3, 0, 0, 0, 5, S5, 0)); // saturates at 5
        vq.push_back(v(2'b00, 2'd0, 0, 0, 0, 0, B,  0));
        vq.push_back(v(2'b01, 2'd0, 1, 0, 0, 4, S4, 1)); // pay
        vq.push_back(v(2'b01, 2'd0, 1, 0, 0, 4, S4, 1)); // second open cycle
        vq.push_back(v(2'b01, 2'd0, 0, 0, 0, 4, S4, 1)); // gate closes
        vq.push_back(v(2'b01, 2'd0, 0, 0, 0, 4, S4, 1));
        vq.push_back(v(2'b00, 2'd0, 0, 0, 0, 0, B,  1));
        vq.push_back(v(2'b11, 2'd2, 0, 0, 1, 0, B,  1)); // two cards: ignored
        vq.push_back(v(2'b00, 2'd0, 0, 0, 0, 0, B,  1));
        vq.push_back(v(2'b10, 2'd2, 0, 0, 0, 2, S2, 1)); // card1 +2
        vq.push_back(v(2'b00, 2'd0, 0, 0, 0, 0, B,  1));
        vq.push_back(v(2'b10, 2'd0, 1, 0, 0, 1, S1, 2)); // card1 pays
        vq.push_back(v(2'b10, 2'd0, 1, 0, 0, 1, S1, 2));
        vq.push_back(v(2'b10, 2'd0, 0, 0, 0, 1, S1, 2));
        vq.push_back(v(2'b01, 2'd0, 0, 0, 0, 4, S4, 2)); // swap, no gap
        vq.push_back(v(2'b01, 2'd0, 0, 0, 0, 4, S4, 2));
        vq.push_back(v(2'b00, 2'd0, 0, 0, 0, 0, B,  2));
        vq.push_back(v(2'b01, 2'd0, 1, 0, 0, 3, S3, 3)); // card0 pays
        vq.push_back(v(2'b01, 2'd0, 1, 0, 0, 3, S3, 3));
        vq.push_back(v(2'b01, 2'd0, 0, 0, 0, 3, S3, 3));
        vq.push_back(v(2'b00, 2'd0, 0, 0, 0, 0, B,  3));

        // Reset state
        #12;
        chk("rst_gate", int'(gate), 0);
        chk("rst_den",  int'(den),  0);
        chk("rst_pc",   int'(pc),   0);
        chk("rst_seg",  int'(sg),   int'(B));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_bal", int'(bal), 0);

        foreach (vq[i]) begin
            sel = vq[i].sel;
            rch = vq[i].rch;
            tick();
            chk($sformatf("v%0d_gate", i), int'(gate), int'(vq[i].gate));
            chk($sformatf("v%0d_den",  i), int'(den),  int'(vq[i].den));
            chk($sformatf("v%0d_err",  i), int'(err),  int'(vq[i].err));
            chk($sformatf("v%0d_bal",  i), int'(bal),  int'(vq[i].bal));
            chk($sformatf("v%0d_seg",  i), int'(sg),   int'(vq[i].seg));
            chk($sformatf("v%0d_pc",   i), int'(pc),   int'(vq[i].pc));
        end
        sel = 2'b10;
        #1;
        chk("card1_kept", int'(bal), 1);
        sel = 2'b00;
        tick();

        // Hold card 0 for 12 clocks: one deduction, gate high 2 clocks.
        gcnt = 0;
        sel  = 2'b01;
        rch  = 2'd0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (gate) gcnt++;
        end
        chk("hold_gate_cycles", gcnt, 2);
        chk("hold_bal", int'(bal), 2);
        chk("hold_pc",  int'(pc),  4);
        sel = 2'b00;
        tick();

        // Asynchronous reset during the second OPEN cycle.
        sel = 2'b01;
        tick();
        chk("pre_rst_gate", int'(gate), 1);
        chk("pre_rst_bal",  int'(bal),  1);
        chk("pre_rst_pc",   int'(pc),   5);
        @(posedge clk);
        #2;
        chk("open2_gate", int'(gate), 1);
        rst_n = 1'b0;
        #1;
        chk("async_gate", int'(gate), 0);
        chk("async_pc",   int'(pc),   0);
        chk("async_bal0", int'(bal),  0);
        sel = 2'b10;
        #1;
        chk("async_bal1", int'(bal),  0);
        sel = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_gate", int'(gate), 0);

        // Second instance: FARE=2, 2-bit pass counter wraps 3 -> 0.
        mb = 0;
        for (int p = 1; p <= 4; p++) begin
            sel2 = 4'b0100;
            rch2 = 2'd3;
            tick();
            mb = (mb + 3 > 5) ? 5 : mb + 3;
            chk($sformatf("w%0d_rch_bal", p), int'(bal2), mb);
            sel2 = 4'b0000;
            tick();
            sel2 = 4'b0100;
            rch2 = 2'd0;
            tick();
            mb = mb - 2;
            chk($sformatf("w%0d_pay_bal", p), int'(bal2),  mb);
            chk($sformatf("w%0d_pc",      p), int'(pc2),   p % 4);
            chk($sformatf("w%0d_gate",    p), int'(gate2), 1);
            tick();
            tick();
            chk($sformatf("w%0d_closed",  p), int'(gate2), 0);
            sel2 = 4'b0000;
            tick();
        end

        // Balance below FARE=2 on card 3 is denied.
        sel2 = 4'b1000;
        rch2 = 2'd1;
        tick();
        sel2 = 4'b0000;
        tick();
        sel2 = 4'b1000;
        rch2 = 2'd0;
        tick();
        chk("w_den",      int'(den2),  1);
        chk("w_den_bal",  int'(bal2),  1);
        chk("w_den_pc",   int'(pc2),   0);
        chk("w_den_gate", int'(gate2), 0);
        sel2 = 4'b0101;
        #1;
        chk("w_multi_err", int'(err2), 1);
        chk("w_multi_bal", int'(bal2), 0);
        chk("w_multi_seg", int'(sg2),  int'(B));
        sel2 = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_catraca_multi
`default_nettype wire

// File: doc/catraca_multi.md
Name: catraca_multi

Overview:
- Parametrised bus-turnstile controller for NCARDS prepaid cards, each holding a saturating credit balance.
- Features: recharge per card, fare deduction, timed gate opening, and edge-qualified card presentation, so one tap equals one transaction.
- Per-card balance is shown on a 7-segment digit.
- Sits between the board switch inputs and the LED/SEG outputs of the top-level FPGA wrapper.

Parameters:
- NCARDS, 2, number of card channels (card_sel width).
- CRED_BITS, 4, width of each balance register.
- MAX_CREDIT, 5, saturation ceiling per card. Must be <= 9 and < 2**CRED_BITS.
- FARE, 1, credits deducted per passage. Must be >= 1.
- RCH_BITS, 2, width of recharge amount.
- OPEN_CYCLES, 2, clocks gate_open stays high per passage. Must be >= 1.
- CNT_BITS, 8, width of pass counter.

Ports:
- clk_2  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- card_sel  in  NCARDS  one-hot card presence (bit i = card i on reader).
- recharge  in  RCH_BITS  credits to add on this tap. 0 means pay-and-pass.
- gate_open  out  1  turnstile released.
- denied  out  1  one-cycle pulse: insufficient balance.
- err_multi  out  1  high while more than one card_sel bit is set.
- balance  out  CRED_BITS  balance of the single presented card, else 0.
- seg  out  7  7-segment pattern of balance (gfedcba, active-high). Blank when no single card.
- pass_count  out  CNT_BITS  total passages since reset, wraps.

Behaviour:
- Reset (async, reset_n=0): all balances 0, state LOCKED, gate_open=0, denied=0, pass_count=0, open timer 0. Reset mid-OPEN closes the gate immediately.
- single = exactly one card_sel bit set. idx = its index. multi = two or more bits set.
- Outputs err_multi, balance and seg are combinational from card_sel and the balance registers. seg shows digits 0..9 with pattern 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101 (6..9 standard).
- Three FSM states: LOCKED, OPEN, WAIT_CLEAR. All changes happen on the clock edge after the input condition.
- LOCKED, single, recharge != 0:
  - bal[idx] <= min(bal[idx] + recharge, MAX_CREDIT), sum computed at CRED_BITS+1 width.
  - Go to WAIT_CLEAR. No gate.
- LOCKED, single, recharge == 0, bal[idx] >= FARE:
  - bal[idx] -= FARE, pass_count += 1 (wraps at 2**CNT_BITS).
  - gate_open=1, timer loaded with OPEN_CYCLES-1, go to OPEN.
- LOCKED, single, recharge == 0, bal[idx] < FARE: denied=1 for one cycle, balance unchanged, go to WAIT_CLEAR.
- LOCKED with zero cards or multi: no action, stay in LOCKED.
- OPEN: gate_open=1. Timer decrements each cycle. When the timer is 0, gate_open<=0 and go to WAIT_CLEAR. Total gate high time is exactly OPEN_CYCLES clocks. Inputs are ignored.
- WAIT_CLEAR: stay until card_sel == 0, then go to LOCKED. A held card or a swapped card never triggers a second transaction.
- Only one transaction per tap, regardless of how long the card is held.
- recharge is sampled only on the transaction cycle.
- Balance arithmetic never underflows or exceeds MAX_CREDIT.
- Cards not selected keep their balance.

Decomposition:
- Package catraca_pkg holds:
  - typedef enum logic [1:0] {LOCKED, OPEN, WAIT_CLEAR} state_t.
  - The 7-segment digit constants SEG_0..SEG_9 and SEG_BLANK.
- One sub-module, seg7_decoder (4-bit value in, 7-bit pattern out). It is reused by later display blocks.
- The balance array, FSM and timer live in catraca_multi.

Test Plan:
- Reset, card_sel=01, recharge=0 -> denied pulse 1 cycle, balance=0, seg=0111111, gate_open stays 0. Remove card -> state LOCKED.
- Card 0, recharge=3, hold 5 cycles -> bal0=3 exactly once. Remove; tap recharge=3 -> bal0=5 (saturated, not 6). seg=1101101.
- Card 0 (bal 5), recharge=0 -> gate_open high exactly OPEN_CYCLES=2 cycles, bal0=4, pass_count=1. Holding the card 10 cycles gives no further deduction.
- card_sel=11 with recharge=2 -> err_multi=1, no balance change on either card, balance=0, seg blank.
- Card 1 bal 2: pay -> bal1=1. Swap directly 10->01 without a zero gap -> no transaction. Then 00 then 01 -> card 0 transaction occurs.
- Assert reset_n=0 in the second OPEN cycle -> gate_open falls asynchronously, all balances 0, pass_count 0. Also run NCARDS=4, FARE=2, CNT_BITS=2 and confirm pass_count wraps 3->0.
